// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the MEM pipeline stage.
//   DATA_W             data path width (32)
//   SIZE_BYTE/HALF/WORD access size encodings of me_c_size (11 acts as word)
//   state_t            access FSM states
//   wb_t               MEM/WB pipeline register contents
package mem_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] pc_plus4;
    logic [4:0]        reg_to_write;
    logic              reg_write;
    logic              data_source;
    logic              halt;
    logic              misalign;
    logic [1:0]        jump;
  } wb_t;

endpackage

// File: rtl/mem_stage_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the data memory.
//   addr_lo    in   byte offset within the word (address bits [1:0])
//   size       in   access size (byte/half/word, 11 treated as word)
//   sign       in   1 = sign-extend loaded byte/half
//   store_data in   right-aligned store data
//   rdata      in   full memory word read for a load
//   wdata      out  store data replicated onto every candidate lane
//   byte_en    out  per-byte write enable (all zero when misaligned)
//   misalign   out  half at odd address or word not on a 4-byte boundary
//   load_data  out  extracted and extended load value (zero when misaligned)
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        byte_en,
  output logic              misalign,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wdata     = store_data;
    byte_en   = 4'b1111;
    misalign  = 1'b0;
    load_data = rdata;
    case (size)
      SIZE_BYTE: begin
        // Replicating the byte lets the enable alone pick the target lane.
        wdata     = {4{store_data[7:0]}};
        byte_en   = 4'b0001 << addr_lo;
        load_data = {{24{sign & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        misalign  = addr_lo[0];
        wdata     = {2{store_data[15:0]}};
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = {{16{sign & half_sel[15]}}, half_sel};
      end
      default: begin
        misalign  = |addr_lo;
      end
    endcase
    if (misalign) begin
      byte_en   = 4'b0000;
      load_data = '0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with word-organised data memory.
//   clk, rst_n          clock / asynchronous active-low reset
//   me_*                EX/MEM inputs, held by upstream while stall_req=1
//   dbg_stall           freezes FSM, MEM/WB register and memory
//   dbg_read_en/addr    debug word read, result in dbg_data next edge
//   stall_req           combinational hold request to upstream
//   wb_*                registered MEM/WB outputs
//   hz_*, fwd_alu_out   hazard/forwarding taps straight from the inputs
// A memory access takes WAIT_CYCLES+2 cycles: one IDLE cycle where the
// array is accessed, then BUSY counting down the wait states.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       me_alu_out,
  input  logic [31:0]       me_store_data,
  input  logic [4:0]        me_reg_to_write,
  input  logic [31:0]       me_pc_plus4,
  input  logic              me_c_reg_write,
  input  logic              me_c_data_source,
  input  logic              me_c_mem_write,
  input  logic              me_c_halt,
  input  logic [1:0]        me_c_jump,
  input  logic [1:0]        me_c_size,
  input  logic              me_c_sign,
  input  logic              dbg_stall,
  input  logic              dbg_read_en,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              stall_req,
  output logic [31:0]       wb_alu_out,
  output logic [31:0]       wb_read_data,
  output logic [31:0]       wb_pc_plus4,
  output logic [4:0]        wb_reg_to_write,
  output logic              wb_c_reg_write,
  output logic              wb_c_data_source,
  output logic              wb_c_halt,
  output logic              wb_misalign,
  output logic [1:0]        wb_c_jump,
  output logic [31:0]       dbg_data,
  output logic              hz_load,
  output logic              hz_reg_write,
  output logic [4:0]        hz_reg_dest,
  output logic [31:0]       fwd_alu_out
);

  logic [DATA_W-1:0] mem_array [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  wb_t         wb_q, wb_d;

  logic              mem_op;
  logic [ADDR_W-1:0] word_idx;
  logic              start_acc, wb_cap, wb_from_mem, wb_bubble, mem_we;
  logic [DATA_W-1:0] store_lanes, load_data;
  logic [3:0]        byte_en;
  logic              lane_misalign;

  assign mem_op   = me_c_data_source | me_c_mem_write;
  assign word_idx = me_alu_out[ADDR_W+1:2];

  mem_lane_align u_align (
    .addr_lo    (me_alu_out[1:0]),
    .size       (me_c_size),
    .sign       (me_c_sign),
    .store_data (me_store_data),
    .rdata      (rdata_q),
    .wdata      (store_lanes),
    .byte_en    (byte_en),
    .misalign   (lane_misalign),
    .load_data  (load_data)
  );

  // Access FSM: the array is touched only on the IDLE->BUSY edge; the
  // inputs stay held through BUSY, so lane extraction can use them then.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_req   = 1'b0;
    start_acc   = 1'b0;
    wb_cap      = 1'b0;
    wb_from_mem = 1'b0;
    wb_bubble   = 1'b0;
    if (dbg_stall) begin
      stall_req = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!mem_op) begin
            wb_cap = 1'b1;
          end else begin
            stall_req = 1'b1;
            wb_bubble = 1'b1;
            // A debug read owns the array this cycle; the access waits.
            if (!dbg_read_en) begin
              start_acc = 1'b1;
              cnt_d     = 4'(WAIT_CYCLES);
              state_d   = BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            stall_req = 1'b1;
            cnt_d     = cnt_q - 4'd1;
          end else begin
            wb_cap      = 1'b1;
            wb_from_mem = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // MEM/WB register: bubbles clear only the control bits, data holds.
  always_comb begin
    wb_d = wb_q;
    if (wb_bubble) begin
      wb_d.reg_write   = 1'b0;
      wb_d.data_source = 1'b0;
      wb_d.halt        = 1'b0;
      wb_d.misalign    = 1'b0;
      wb_d.jump        = 2'b00;
    end
    if (wb_cap) begin
      wb_d.alu_out      = me_alu_out;
      wb_d.read_data    = wb_from_mem ? load_data : '0;
      wb_d.pc_plus4     = me_pc_plus4;
      wb_d.reg_to_write = me_reg_to_write;
      wb_d.reg_write    = me_c_reg_write;
      wb_d.data_source  = me_c_data_source;
      wb_d.halt         = me_c_halt;
      wb_d.misalign     = wb_from_mem & lane_misalign;
      wb_d.jump         = me_c_jump;
    end
  end

  assign dbg_data_d = dbg_read_en ? mem_array[dbg_addr] : dbg_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      wb_q       <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_q       <= wb_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  // Array is not reset; writes are suppressed while reset is asserted.
  assign mem_we = start_acc & me_c_mem_write & rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_array[word_idx][8*b +: 8] <= store_lanes[8*b +: 8];
      end
    end
    if (start_acc) rdata_q <= mem_array[word_idx];
  end

  assign wb_alu_out       = wb_q.alu_out;
  assign wb_read_data     = wb_q.read_data;
  assign wb_pc_plus4      = wb_q.pc_plus4;
  assign wb_reg_to_write  = wb_q.reg_to_write;
  assign wb_c_reg_write   = wb_q.reg_write;
  assign wb_c_data_source = wb_q.data_source;
  assign wb_c_halt        = wb_q.halt;
  assign wb_misalign      = wb_q.misalign;
  assign wb_c_jump        = wb_q.jump;
  assign dbg_data         = dbg_data_q;

  assign hz_load      = me_c_data_source;
  assign hz_reg_write = me_c_reg_write;
  assign hz_reg_dest  = me_reg_to_write;
  assign fwd_alu_out  = me_alu_out;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage.
// u_dut0 runs with WAIT_CYCLES=0, u_dut3 with WAIT_CYCLES=3. Both share the
// me_* inputs; whichever one is not under test is frozen with dbg_stall.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] me_alu_out, me_store_data, me_pc_plus4;
  logic [4:0]  me_reg_to_write;
  logic        me_c_reg_write, me_c_data_source, me_c_mem_write, me_c_halt, me_c_sign;
  logic [1:0]  me_c_jump, me_c_size;
  logic        dbg_stall0, dbg_stall3, dbg_read_en;
  logic [5:0]  dbg_addr;

  logic        stall0, wb_rw0, wb_ds0, wb_halt0, wb_mis0, hz_load0, hz_rw0;
  logic [31:0] wb_alu0, wb_rd0, wb_pc0, dbg_data0, fwd0;
  logic [4:0]  wb_dst0, hz_dst0;
  logic [1:0]  wb_jump0;

  logic        stall3, wb_rw3, wb_ds3, wb_halt3, wb_mis3, hz_load3, hz_rw3;
  logic [31:0] wb_alu3, wb_rd3, wb_pc3, dbg_data3, fwd3;
  logic [4:0]  wb_dst3, hz_dst3;
  logic [1:0]  wb_jump3;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(6), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .me_alu_out(me_alu_out), .me_store_data(me_store_data),
    .me_reg_to_write(me_reg_to_write), .me_pc_plus4(me_pc_plus4),
    .me_c_reg_write(me_c_reg_write), .me_c_data_source(me_c_data_source),
    .me_c_mem_write(me_c_mem_write), .me_c_halt(me_c_halt),
    .me_c_jump(me_c_jump), .me_c_size(me_c_size), .me_c_sign(me_c_sign),
    .dbg_stall(dbg_stall0), .dbg_read_en(dbg_read_en), .dbg_addr(dbg_addr),
    .stall_req(stall0), .wb_alu_out(wb_alu0), .wb_read_data(wb_rd0),
    .wb_pc_plus4(wb_pc0), .wb_reg_to_write(wb_dst0), .wb_c_reg_write(wb_rw0),
    .wb_c_data_source(wb_ds0), .wb_c_halt(wb_halt0), .wb_misalign(wb_mis0),
    .wb_c_jump(wb_jump0), .dbg_data(dbg_data0), .hz_load(hz_load0),
    .hz_reg_write(hz_rw0), .hz_reg_dest(hz_dst0), .fwd_alu_out(fwd0)
  );

  mem_stage #(.ADDR_W(6), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .me_alu_out(me_alu_out), .me_store_data(me_store_data),
    .me_reg_to_write(me_reg_to_write), .me_pc_plus4(me_pc_plus4),
    .me_c_reg_write(me_c_reg_write), .me_c_data_source(me_c_data_source),
    .me_c_mem_write(me_c_mem_write), .me_c_halt(me_c_halt),
    .me_c_jump(me_c_jump), .me_c_size(me_c_size), .me_c_sign(me_c_sign),
    .dbg_stall(dbg_stall3), .dbg_read_en(dbg_read_en), .dbg_addr(dbg_addr),
    .stall_req(stall3), .wb_alu_out(wb_alu3), .wb_read_data(wb_rd3),
    .wb_pc_plus4(wb_pc3), .wb_reg_to_write(wb_dst3), .wb_c_reg_write(wb_rw3),
    .wb_c_data_source(wb_ds3), .wb_c_halt(wb_halt3), .wb_misalign(wb_mis3),
    .wb_c_jump(wb_jump3), .dbg_data(dbg_data3), .hz_load(hz_load3),
    .hz_reg_write(hz_rw3), .hz_reg_dest(hz_dst3), .fwd_alu_out(fwd3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nop();
    me_alu_out = 32'h0; me_store_data = 32'h0; me_pc_plus4 = 32'h0;
    me_reg_to_write = 5'd0; me_c_reg_write = 1'b0; me_c_data_source = 1'b0;
    me_c_mem_write = 1'b0; me_c_halt = 1'b0; me_c_jump = 2'b00;
    me_c_size = 2'b10; me_c_sign = 1'b0;
  endtask

  task automatic set_mem(input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [1:0] size, input bit sgn, input bit is_load);
    me_alu_out = addr; me_store_data = sdata; me_pc_plus4 = addr + 32'd4;
    me_reg_to_write = 5'd7; me_c_reg_write = is_load; me_c_data_source = is_load;
    me_c_mem_write = !is_load; me_c_halt = 1'b0; me_c_jump = 2'b00;
    me_c_size = size; me_c_sign = sgn;
  endtask

  // Called just after a negedge. Holds the op while the selected DUT stalls,
  // counts stall cycles, notes any wb reg_write seen while stalled, and
  // returns at the negedge after completion with a nop driven.
  task automatic mem_op(input bit use3, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [1:0] size, input bit sgn, input bit is_load,
                        output int stalls, output bit rw_seen);
    logic s;
    set_mem(addr, sdata, size, sgn, is_load);
    stalls = 0;
    rw_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1 s = use3 ? stall3 : stall0;
      @(posedge clk);
      if (!s) break;
      stalls++;
      @(negedge clk);
      if ((use3 ? wb_rw3 : wb_rw0) === 1'b1) rw_seen = 1'b1;
    end
    @(negedge clk);
    nop();
  endtask

  task automatic nonmem(input logic [31:0] alu, input logic [31:0] pc, input logic [4:0] rd);
    nop();
    me_alu_out = alu; me_pc_plus4 = pc; me_reg_to_write = rd;
    me_c_reg_write = 1'b1; me_c_jump = 2'b10;
    #1;
    chk("nm_stall", 32'(stall0), 32'd0);
    chk("nm_hz_dest", 32'(hz_dst0), 32'(rd));
    chk("nm_fwd", fwd0, alu);
    @(posedge clk);
    @(negedge clk);
    chk("nm_wb_alu", wb_alu0, alu);
    chk("nm_wb_pc", wb_pc0, pc);
    chk("nm_wb_jump", 32'(wb_jump0), 32'd2);
  endtask

  initial begin
    int st;
    bit rw;
    logic s;

    nop();
    rst_n = 1'b0; dbg_stall0 = 1'b0; dbg_stall3 = 1'b1;
    dbg_read_en = 1'b0; dbg_addr = 6'd0;
    repeat (3) @(negedge clk);
    chk("rst_wb_alu", wb_alu0, 32'h0);
    chk("rst_wb_rw", 32'(wb_rw0), 32'd0);
    chk("rst_dbg", dbg_data0, 32'h0);
    chk("rst_stall", 32'(stall0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store / load, no wait states.
    mem_op(0, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0, st, rw);
    chk("sw_stall", 32'(st), 32'd1);
    mem_op(0, 32'h10, 32'h0, 2'b10, 0, 1, st, rw);
    chk("lw_stall", 32'(st), 32'd1);
    chk("lw_data", wb_rd0, 32'hDEADBEEF);
    chk("lw_rw", 32'(wb_rw0), 32'd1);
    chk("lw_mis", 32'(wb_mis0), 32'd0);

    // Byte store into top lane of a cleared word, then lane loads.
    mem_op(0, 32'h10, 32'h0, 2'b10, 0, 0, st, rw);
    mem_op(0, 32'h13, 32'h00000080, 2'b00, 0, 0, st, rw);
    mem_op(0, 32'h13, 32'h0, 2'b00, 1, 1, st, rw);
    chk("lb_signed", wb_rd0, 32'hFFFFFF80);
    mem_op(0, 32'h13, 32'h0, 2'b00, 0, 1, st, rw);
    chk("lb_unsigned", wb_rd0, 32'h00000080);
    mem_op(0, 32'h10, 32'h0, 2'b10, 0, 1, st, rw);
    chk("lw_after_sb", wb_rd0, 32'h80000000);
    mem_op(0, 32'h12, 32'h0, 2'b01, 1, 1, st, rw);
    chk("lh_signed_hi", wb_rd0, 32'hFFFF8000);

    // Misaligned accesses.
    mem_op(0, 32'h11, 32'h0, 2'b01, 0, 1, st, rw);
    chk("mis_half_flag", 32'(wb_mis0), 32'd1);
    chk("mis_half_data", wb_rd0, 32'h0);
    chk("mis_half_stall", 32'(st), 32'd1);
    mem_op(0, 32'h12, 32'h12345678, 2'b10, 0, 0, st, rw);
    chk("mis_sw_flag", 32'(wb_mis0), 32'd1);
    mem_op(0, 32'h10, 32'h0, 2'b10, 0, 1, st, rw);
    chk("mis_sw_nowrite", wb_rd0, 32'h80000000);
    chk("mis_clear", 32'(wb_mis0), 32'd0);

    // Non-memory op, then a load deferred by a debug read.
    nonmem(32'h1234, 32'h44, 5'd9);
    set_mem(32'h10, 32'h0, 2'b10, 0, 1);
    dbg_read_en = 1'b1; dbg_addr = 6'd4;
    #1 chk("defer_stall", 32'(stall0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("dbg_word4", dbg_data0, 32'h80000000);
    chk("defer_bubble", 32'(wb_rw0), 32'd0);
    chk("defer_still", 32'(stall0), 32'd1);
    dbg_read_en = 1'b0;
    mem_op(0, 32'h10, 32'h0, 2'b10, 0, 1, st, rw);
    chk("defer_done_stall", 32'(st), 32'd1);
    chk("defer_done_data", wb_rd0, 32'h80000000);

    // Reset while BUSY after a store: outputs clear, store persists.
    nonmem(32'h1234, 32'h48, 5'd3);
    set_mem(32'h20, 32'h11223344, 2'b10, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_hold", wb_alu0, 32'h1234);
    rst_n = 1'b0;
    nop();
    #1;
    chk("busy_rst_alu", wb_alu0, 32'h0);
    chk("busy_rst_pc", wb_pc0, 32'h0);
    chk("busy_rst_stall", 32'(stall0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_op(0, 32'h20, 32'h0, 2'b10, 0, 1, st, rw);
    chk("post_rst_stall", 32'(st), 32'd1);
    chk("post_rst_data", wb_rd0, 32'h11223344);

    // Three wait states on the second instance.
    dbg_stall0 = 1'b1; dbg_stall3 = 1'b0;
    @(negedge clk);
    mem_op(1, 32'h08, 32'hA5A50001, 2'b10, 0, 0, st, rw);
    chk("w3_sw_stall", 32'(st), 32'd4);
    mem_op(1, 32'h08, 32'h0, 2'b10, 0, 1, st, rw);
    chk("w3_lw_stall", 32'(st), 32'd4);
    chk("w3_bubble_rw", 32'(rw), 32'd0);
    chk("w3_lw_rw", 32'(wb_rw3), 32'd1);
    chk("w3_lw_data", wb_rd3, 32'hA5A50001);

    // Freeze mid-BUSY (two wait states left) for 5 cycles.
    set_mem(32'h0A, 32'h0, 2'b01, 1, 1);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    dbg_stall3 = 1'b1; dbg_read_en = 1'b1; dbg_addr = 6'd2;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      chk("frz_stall", 32'(stall3), 32'd1);
    end
    chk("frz_rw", 32'(wb_rw3), 32'd0);
    chk("frz_wb_rd", wb_rd3, 32'hA5A50001);
    chk("frz_dbg", dbg_data3, 32'hA5A50001);
    dbg_read_en = 1'b0; dbg_stall3 = 1'b0;
    st = 0;
    for (int i = 0; i < 40; i++) begin
      #1 s = stall3;
      @(posedge clk);
      if (!s) break;
      st++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("frz_resume_stall", 32'(st), 32'd2);
    chk("frz_resume_data", wb_rd3, 32'hFFFFA5A5);
    chk("frz_resume_rw", 32'(wb_rw3), 32'd1);
    nop();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised pipeline memory stage (MEM) sitting between the EX/MEM and MEM/WB boundaries. Holds a byte-addressed, word-organised data memory with byte/half/word loads and stores, sign/zero load extension, configurable access latency with a stall request to upstream, misalignment detection, and a debug read port. It also registers the MEM/WB pipeline register and exports hazard/forwarding taps.

## Interface
- ADDR_W, 6, word-address width; depth = 2**ADDR_W words of 32 bits
- WAIT_CYCLES, 0, extra wait states per memory access, legal 0..15
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- me_alu_out  in  32  byte address for loads/stores; ALU result otherwise
- me_store_data  in  32  store data, right-aligned
- me_reg_to_write  in  5  destination register
- me_pc_plus4  in  32  PC+4 of the instruction
- me_c_reg_write, me_c_data_source (1 = load), me_c_mem_write, me_c_halt  in  1 each  control
- me_c_jump  in  2  passed to WB
- me_c_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- me_c_sign  in  1  1 = sign-extend loads
- dbg_stall  in  1  freezes the stage
- dbg_read_en  in  1  debug read request
- dbg_addr  in  ADDR_W  debug word address
- stall_req  out  1  combinational; upstream holds all me_* inputs while 1
- wb_alu_out, wb_read_data, wb_pc_plus4  out  32  registered
- wb_reg_to_write  out  5  registered
- wb_c_reg_write, wb_c_data_source, wb_c_halt, wb_misalign  out  1  registered
- wb_c_jump  out  2  registered
- dbg_data  out  32  registered debug read word
- hz_load, hz_reg_write  out  1  = me_c_data_source, me_c_reg_write
- hz_reg_dest  out  5  = me_reg_to_write; fwd_alu_out  out  32  = me_alu_out

## Operation
- mem op = me_c_data_source | me_c_mem_write. Word index = me_alu_out[ADDR_W+1:2]; upper bits ignored (wrap).
- FSM IDLE/BUSY, counter cnt of 4 bits.
- IDLE, no mem op: stall_req=0; MEM/WB captures inputs.
- IDLE, mem op, dbg_read_en=0, dbg_stall=0: stall_req=1; at edge: store commits (byte lanes per size/addr[1:0]), load word latched into rdata; cnt<=WAIT_CYCLES; ->BUSY. MEM/WB control bits captured as bubble (reg_write, data_source, halt, jump, misalign = 0); data regs hold.
- IDLE, mem op, dbg_read_en=1: access deferred, stay IDLE, stall_req=1, bubble.
- BUSY: stall_req = (cnt!=0); cnt decrements while nonzero; at cnt==0 edge MEM/WB captures with wb_read_data = extracted/extended lane of rdata; ->IDLE.
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no write, wb_read_data=0, wb_misalign=1 for that instruction; normal latency.
- Load extract: byte lane addr[1:0], half lane addr[1]; zero- or sign-extend per me_c_sign.
- dbg_read_en=1: dbg_data <= mem[dbg_addr] at edge, any state.
- dbg_stall=1: FSM, cnt, MEM/WB regs, memory all hold; stall_req forced 1; dbg port still works.
- Reset: all registered outputs 0, dbg_data 0, state IDLE, cnt 0; array contents not cleared. Reset in BUSY aborts; committed store persists.

## Timing
- Non-memory instruction: 1 cycle in stage, visible at wb_* after next edge.
- Memory instruction: WAIT_CYCLES+2 cycles, stall_req high for WAIT_CYCLES+1 cycles.
- Store and debug read of same word in same edge: dbg_data returns old value.
- Back-to-back loads: second starts the cycle after first leaves BUSY.

## Structure
- Package mem_stage_pkg: size encodings SIZE_BYTE/HALF/WORD, state enum IDLE/BUSY, DATA_W=32 constant.
- Sub-module mem_lane_align (combinational): store lane shift + 4-bit byte enable, misalign flag, load extract/extend.

## Test plan
- Word store 0xDEADBEEF to addr 0x10, then word load addr 0x10, WAIT_CYCLES=0 -> wb_read_data=0xDEADBEEF, stall_req high exactly 1 cycle per op.
- Byte store 0x80 to addr 0x13 over word 0, signed byte load addr 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word load 0x10 -> 0x80000000 after prior 0.
- WAIT_CYCLES=3, load -> stall_req high 4 cycles, wb_c_reg_write=0 during bubbles, 1 on completion.
- Half load addr 0x11 -> wb_misalign=1, wb_read_data=0; word store addr 0x12 -> memory unchanged.
- dbg_stall=1 mid-BUSY for 5 cycles -> wb_* and cnt frozen, completion resumes with correct data; dbg_read_en with dbg_addr=4 -> dbg_data = mem[4].
- rst_n low in BUSY after store -> outputs 0, IDLE; subsequent load sees stored value.
